// File: rtl/boolean_ca_pkg.sv
// boolean_ca_pkg
// Shared widths and FSM state encoding for the Boolean CA sweep sequencer.
//   VEC_W    : width of the {A,B,C,D} input vector
//   TALLY_W  : width of the E/F hit counters (holds 0..16)
//   SETTLE_W : width of the settle down-counter (holds 0..15)
package boolean_ca_pkg;

    localparam int unsigned VEC_W    = 4;
    localparam int unsigned TALLY_W  = 5;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
// Loadable down-counter used to time the settle wait after a vector is driven.
// Ports:
//   clock, reset_b : clock and asynchronous active-low reset
//   load, load_val : load the counter (has priority over dec)
//   dec            : decrement by one, saturating at zero
//   zero           : counter currently holds zero
//   expire         : counter holds one, so a decrement this cycle reaches zero
module settle_timer
    import boolean_ca_pkg::*;
(
    input  logic                clock,
    input  logic                reset_b,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero,
    output logic                expire
);

    logic [SETTLE_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero   = (count_q == '0);
    assign expire = (count_q == SETTLE_W'(1));

endmodule

// File: rtl/boolean_ca_sequencer.sv
// boolean_ca_sequencer
// Sweeps an inclusive, wrapping range of 4-bit vectors onto the Boolean CA
// datapath, waits SETTLE_CYCLES, samples E/F and streams each result out while
// counting E=1 and F=1 hits.
// Ports:
//   clock, reset_b        : clock and asynchronous active-low reset
//   start, abort          : begin a sweep (IDLE only) / cut an active sweep short
//   first_vec, last_vec   : inclusive sweep range, latched on start
//   A, B, C, D            : current vector driven to the datapath
//   E, F                  : datapath outputs
//   busy                  : high whenever not IDLE
//   result_valid          : one-cycle pulse per sampled vector
//   result_vec, result_ef : vector and {E,F} of the current result
//   tally_e, tally_f      : E=1 / F=1 counts for this sweep
//   done                  : one-cycle pulse on normal completion
module boolean_ca_sequencer
    import boolean_ca_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic               start,
    input  logic               abort,
    input  logic [VEC_W-1:0]   first_vec,
    input  logic [VEC_W-1:0]   last_vec,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               D,
    input  logic               E,
    input  logic               F,
    output logic               busy,
    output logic               result_valid,
    output logic [VEC_W-1:0]   result_vec,
    output logic [1:0]         result_ef,
    output logic [TALLY_W-1:0] tally_e,
    output logic [TALLY_W-1:0] tally_f,
    output logic               done
);

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES);

    state_e             state_q;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   last_q;
    logic               busy_q;
    logic               result_valid_q;
    logic [VEC_W-1:0]   result_vec_q;
    logic [1:0]         result_ef_q;
    logic [TALLY_W-1:0] tally_e_q;
    logic [TALLY_W-1:0] tally_f_q;
    logic               done_q;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic timer_expire;

    assign timer_load = (state_q == StDrive);
    assign timer_dec  = (state_q == StSettle);

    settle_timer u_settle_timer (
        .clock    (clock),
        .reset_b  (reset_b),
        .load     (timer_load),
        .load_val (SettleLoad),
        .dec      (timer_dec),
        .zero     (timer_zero),
        .expire   (timer_expire)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= StIdle;
            vec_q          <= '0;
            last_q         <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_vec_q   <= '0;
            result_ef_q    <= '0;
            tally_e_q      <= '0;
            tally_f_q      <= '0;
            done_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // start beats a simultaneous abort here
                    if (start) begin
                        last_q    <= last_vec;
                        vec_q     <= first_vec;
                        tally_e_q <= '0;
                        tally_f_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StDrive;
                    end
                end
                StDrive: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (SettleLoad == '0) begin
                        state_q <= StSample;
                    end else begin
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (timer_expire || timer_zero) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    // the sample is reported even when aborting in this cycle
                    result_ef_q    <= {E, F};
                    result_vec_q   <= vec_q;
                    result_valid_q <= 1'b1;
                    tally_e_q      <= tally_e_q + {{(TALLY_W-1){1'b0}}, E};
                    tally_f_q      <= tally_f_q + {{(TALLY_W-1){1'b0}}, F};
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (vec_q == last_q) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        state_q <= StDrive;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign {A, B, C, D}  = vec_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_vec   = result_vec_q;
    assign result_ef    = result_ef_q;
    assign tally_e      = tally_e_q;
    assign tally_f      = tally_f_q;
    assign done         = done_q;

endmodule

// File: doc/boolean_ca_sequencer.md
# boolean_ca_sequencer

Sequencing controller for the `Circuit_Boolean_CA` combinational datapath (inputs A,B,C,D; outputs E,F). On a start request it walks a programmable inclusive range of 4-bit input vectors and drives each one onto A..D. It waits a fixed settle interval, samples E/F, and streams each result out. It also keeps running counts of vectors that produced E=1 and F=1. It replaces hand-written stimulus sequences with a reusable, synthesizable sweep engine that sits between a host/bench and the datapath.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: number of wait cycles between driving a vector and sampling E/F. Legal range is 0..15.

Ports:
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset_b`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; only honoured in IDLE.
- `abort`  in  1  terminate an active sweep.
- `first_vec`  in  4  first vector {A,B,C,D}; latched on start.
- `last_vec`  in  4  last vector, inclusive; latched on start.
- `A`,`B`,`C`,`D`  out  1 each  drive to the datapath; {A,B,C,D} = current vector register.
- `E`,`F`  in  1 each  datapath outputs.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse per sampled vector.
- `result_vec`  out  4  vector associated with the current result.
- `result_ef`  out  2  {E,F} as sampled.
- `tally_e`  out  5  count of sampled vectors with E=1 in this sweep.
- `tally_f`  out  5  count of sampled vectors with F=1 in this sweep.
- `done`  out  1  one-cycle pulse when a sweep completes normally.

## Operation
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If `start`=1: latch `first_vec`/`last_vec`, set the vector register to `first_vec`, clear both tallies, and go to DRIVE.
  - Otherwise hold. {A,B,C,D} keep their last value.
- DRIVE: one cycle. Load the settle counter with `SETTLE_CYCLES`. Go to SETTLE if `SETTLE_CYCLES`>0, else go to SAMPLE.
- SETTLE: decrement the counter each cycle. Go to SAMPLE when it reaches 0 after `SETTLE_CYCLES` cycles.
- SAMPLE:
  - Register {E,F} into `result_ef` and the vector into `result_vec`. Assert `result_valid` in the following cycle.
  - Increment `tally_e` if E=1 and `tally_f` if F=1.
  - If vector == latched last: go to DONE.
  - Otherwise increment the vector (4-bit, mod 16) and go to DRIVE.
- DONE: assert `done` for one cycle, then go to IDLE.
- Range and wrap:
  - The sweep length is ((last − first) mod 16) + 1, i.e. 1..16 vectors.
  - If first > last, the count wraps 15→0.
  - If first == last, exactly one vector is swept.
- `start` while busy is ignored. `start` and `abort` together in IDLE: start wins and abort is ignored.
- `abort` in DRIVE, SETTLE or SAMPLE:
  - Go to IDLE at the next edge. No `done` pulse.
  - If abort arrives in SAMPLE, that sample is still taken and reported.
  - Tallies retain their partial values.
- `abort` in DONE has no effect; the `done` pulse still occurs.
- Reset (async, any state): state=IDLE; A..D=0; `busy`, `result_valid`, `done`=0; `result_vec`=0; `result_ef`=0; tallies=0. Reset asserted mid-sweep discards the sweep immediately.

## Timing
- Edge 0 samples `start`=1. {A,B,C,D}=first_vec from edge 0 onward; `busy`=1 from edge 0 onward.
- Each vector occupies SETTLE_CYCLES+2 cycles (DRIVE + SETTLE + SAMPLE).
- The datapath input is stable for SETTLE_CYCLES+1 cycles before E/F are sampled.
- `result_valid` goes high one cycle after each SAMPLE cycle. Tallies update at the same edge.
- `done` goes high N·(SETTLE_CYCLES+2) cycles after edge 0, for one cycle. `busy` drops at the end of DONE.
- A new `start` is accepted on the first IDLE cycle after DONE.
- Outputs are registered; there is no combinational path from E/F to any output.

## Structure
- Package `boolean_ca_pkg`:
  - state encoding typedef (5 states);
  - `VEC_W`=4, `TALLY_W`=5, `SETTLE_W`=4.
- Sub-module `settle_timer`: a loadable down-counter with a zero flag, used for the SETTLE wait.
- Top-level integration instantiates `boolean_ca_sequencer` and `Circuit_Boolean_CA` side by side; that wrapper is outside this block.

## Test plan
The bench datapath model is E = A^B^C^D and F = A&B&C&D.
- Full sweep, first=0, last=15, SETTLE=2 -> 16 `result_valid` pulses with result_vec 0..15 in order; tally_e=8, tally_f=1; `done` 64 cycles after start.
- Single vector, first=last=5 (0101), SETTLE=0 -> one result with result_ef=2'b00; tally_e=0; `done` 2 cycles after start.
- Wrap range, first=14, last=1 -> vectors 14,15,0,1; result_ef E bits 1,0,0,1; tally_e=2, tally_f=1.
- Abort during SETTLE of vector 3 of a 0..15 sweep -> IDLE next cycle, `busy`=0, no `done`, tally_e=2 (from vectors 1,2).
- `start` pulsed again mid-sweep -> ignored; sweep completes unchanged.
- `reset_b` pulled low mid-sweep, asynchronously between edges -> all outputs 0 immediately; a subsequent `start` runs a clean sweep.
